maxpool_2x2: RTL
================

// Module: maxpool_2x2
// PURPOSE
//   Sequential 2x2/stride-2 max-pooling stage directly downstream of the ReLU
//   stage. Captures a MATRIX_SIZE x MATRIX_SIZE signed matrix on a start strobe,
//   walks the (MATRIX_SIZE/2)^2 non-overlapping windows one per clock, and writes
//   each window maximum into a registered half-size output matrix. Pulses done
//   when the full pooled matrix is valid.
// PARAMETERS
//   DATA_WIDTH   8    bit width of each signed element (input and output)
//   MATRIX_SIZE  16   input matrix dimension; must be even
//   OUT_SIZE     MATRIX_SIZE/2 (localparam) output matrix dimension
// PORTS
//   clk       in   1                                   rising-edge clock
//   rst       in   1                                   asynchronous, active-high reset
//   start     in   1                                   capture data_in and begin pooling (honoured only in IDLE)
//   data_in   in   signed [DATA_WIDTH-1:0] [MATRIX_SIZE][MATRIX_SIZE]   ReLU output matrix
//   busy      out  1                                   high in RUN and DONE
//   done      out  1                                   one-cycle pulse: data_out complete
//   data_out  out  signed [DATA_WIDTH-1:0] [OUT_SIZE][OUT_SIZE]         pooled matrix (registered)
// BEHAVIOUR
//   - Clock/reset: single clock clk; rst is asynchronous and active-high.
//   - Reset (async, any state): state=IDLE, win_idx=0, busy=0, done=0, data_out all 0,
//     input buffer all 0. Reset mid-run abandons the run; no done is issued.
//   - FSM states IDLE, RUN, DONE:
//     IDLE: start=1 at an edge -> buf<=data_in (whole matrix), data_out<=all 0,
//           win_idx<=0, state<=RUN. start=0 -> stay.
//     RUN:  each edge: r=win_idx/OUT_SIZE, c=win_idx%OUT_SIZE (row-major);
//           data_out[r][c] <= signed max(buf[2r][2c], buf[2r][2c+1],
//           buf[2r+1][2c], buf[2r+1][2c+1]); win_idx++.
//           When win_idx==OUT_SIZE^2-1 on that edge -> state<=DONE.
//     DONE: done=1, busy=1 for exactly this cycle; next edge -> IDLE.
//   - start outside IDLE is ignored (no queueing); data_in changes after capture
//     have no effect on the run in progress.
//   - Latency: start sampled at edge E0; RUN spans edges E1..E64 (default sizes);
//     done high in the cycle following E64 (i.e. after edge E64, until E65).
//     start held high continuously -> a new capture every OUT_SIZE^2+2 cycles (66).
//   - Arithmetic: two's-complement signed comparison, no widening or saturation;
//     output width equals input width. Ties: value is identical, any operand OK.
//   - Window maximum built as a two-level compare tree, single cycle, no pipeline.
//   - data_out holds its last value in IDLE until the next accepted start, which
//     clears it to 0; partially written data_out is only guaranteed valid at done.
//   - win_idx width: $clog2(OUT_SIZE*OUT_SIZE); never wraps within a run.
// TESTING
//   1. All-zero input, start 1 cycle -> done exactly once, 65 cycles after start
//      edge; data_out all 0; busy high for 65 cycles.
//   2. data_in[i][j]=i+j -> data_out[r][c]=2r+2c+2 for all r,c in 0..7.
//   3. data_in all -5 except data_in[3][2]=7 -> data_out[1][1]=7, all others -5
//      (checks signed compare, not unsigned).
//   4. start run A, then start with different matrix B at RUN cycle 10 -> B ignored,
//      output equals pool(A), single done pulse, no second run.
//   5. rst asserted at RUN cycle 30 -> busy=0, done=0, data_out all 0 immediately
//      (async); subsequent start completes normally with correct result.
//   6. start held high, input alternating between two matrices -> done every 66
//      cycles; each result matches the matrix present at its capture edge.

Source files
------------

// File: rtl/maxpool_2x2_if.sv
// Handshake and matrix bus between the ReLU stage (master) and the 2x2 max-pool stage (slave).
// The master drives start and the input matrix; the slave returns status and the pooled matrix.
interface maxpool_2x2_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 16
);
  localparam int OUT_SIZE = MATRIX_SIZE / 2;

  logic                         start;
  logic signed [DATA_WIDTH-1:0] data_in  [MATRIX_SIZE][MATRIX_SIZE];
  logic                         busy;
  logic                         done;
  logic signed [DATA_WIDTH-1:0] data_out [OUT_SIZE][OUT_SIZE];

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  data_out
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output data_out
  );
endinterface

// File: rtl/maxpool_2x2.sv
// Sequential 2x2 / stride-2 max-pooling: captures a matrix on start, reduces one window per clock,
// and pulses done once the registered half-size result is complete.
module maxpool_2x2 #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 16
) (
  input  logic          clk,
  input  logic          rst,
  maxpool_2x2_if.slave  bus
);
  localparam int OUT_SIZE = MATRIX_SIZE / 2;
  localparam int N_WIN    = OUT_SIZE * OUT_SIZE;
  localparam int WIN_W    = (N_WIN > 1) ? $clog2(N_WIN) : 1;
  localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(N_WIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                       r_state;
  logic [WIN_W-1:0]             r_win_idx;
  logic                         r_busy;
  logic                         r_done;
  logic signed [DATA_WIDTH-1:0] r_buf [MATRIX_SIZE][MATRIX_SIZE];
  logic signed [DATA_WIDTH-1:0] r_out [OUT_SIZE][OUT_SIZE];

  logic signed [DATA_WIDTH-1:0] w_a;
  logic signed [DATA_WIDTH-1:0] w_b;
  logic signed [DATA_WIDTH-1:0] w_c;
  logic signed [DATA_WIDTH-1:0] w_d;
  logic signed [DATA_WIDTH-1:0] w_max_top;
  logic signed [DATA_WIDTH-1:0] w_max_bot;
  logic signed [DATA_WIDTH-1:0] w_max;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_a = '0;
    w_b = '0;
    w_c = '0;
    w_d = '0;
    for (int r = 0; r < OUT_SIZE; r++) begin
      for (int c = 0; c < OUT_SIZE; c++) begin
        if (r_win_idx == WIN_W'(r * OUT_SIZE + c)) begin
          w_a = r_buf[2*r][2*c];
          w_b = r_buf[2*r][2*c+1];
          w_c = r_buf[2*r+1][2*c];
          w_d = r_buf[2*r+1][2*c+1];
        end
      end
    end
  end

  // Two-level signed compare tree; ties may pick either operand since the value is identical.
  assign w_max_top = (w_a > w_b) ? w_a : w_b;
  assign w_max_bot = (w_c > w_d) ? w_c : w_d;
  assign w_max     = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_win_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      // NOTE: the capture buffer and result array are reset too, so a run abandoned by reset
      // leaves a defined all-zero output rather than stale data.
      r_buf     <= '{default: '0};
      r_out     <= '{default: '0};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_buf     <= bus.data_in;
            r_out     <= '{default: '0};
            r_win_idx <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          for (int r = 0; r < OUT_SIZE; r++) begin
            for (int c = 0; c < OUT_SIZE; c++) begin
              if (r_win_idx == WIN_W'(r * OUT_SIZE + c)) begin
                r_out[r][c] <= w_max;
              end
            end
          end
          if (r_win_idx == LAST_WIN) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_win_idx <= r_win_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.data_out = r_out;

endmodule
